bbox_scan_engine: RTL

Parametrised bounding-box engine for the image-processing datapath. It holds one IMG_W×IMG_H greyscale frame in on-chip RAM, loaded over a simple write port. On `start`, it raster-scans the frame and reports the bounding box and count of all pixels at or above a programmable threshold. It supports arbitrary frame geometry, a runtime threshold, explicit busy/done/found status and an empty-frame indication, all driven from the Avalon-facing wrapper.

---
 rtl/bbox_scan_engine_if.sv | 36 +++
 rtl/bbox_scan_engine.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/bbox_scan_engine_if.sv
// Control/status bundle between the Avalon-facing wrapper (master) and bbox_scan_engine (slave).
// Field widths follow the same frame geometry parameters as the engine.
interface bbox_scan_engine_if #(
    parameter int IMG_W   = 100,
    parameter int IMG_H   = 100,
    parameter int PIX_W   = 8,
    parameter int COORD_W = 8
);
    localparam int N      = IMG_W * IMG_H;
    localparam int ADDR_W = $clog2(N);
    localparam int CNT_W  = $clog2(N + 1);

    logic                wr_en;
    logic [ADDR_W-1:0]   wr_addr;
    logic [PIX_W-1:0]    wr_data;
    logic [PIX_W-1:0]    threshold;
    logic                start;
    logic                busy;
    logic                done;
    logic                found;
    logic [COORD_W-1:0]  xMin;
    logic [COORD_W-1:0]  xMax;
    logic [COORD_W-1:0]  yMin;
    logic [COORD_W-1:0]  yMax;
    logic [CNT_W-1:0]    pix_count;

    modport master (
        output wr_en, wr_addr, wr_data, threshold, start,
        input  busy, done, found, xMin, xMax, yMin, yMax, pix_count
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, threshold, start,
        output busy, done, found, xMin, xMax, yMin, yMax, pix_count
    );
endinterface

// File: rtl/bbox_scan_engine.sv
// Frame-buffered bounding-box engine: raster-scans the stored frame and reports
// the box and count of pixels at or above a latched threshold.
//
// state  | meaning
// IDLE   | accepts pixel writes and start; outputs hold last result
// SCAN   | one RAM read per cycle, addresses 0..N-1
// DRAIN  | evaluates the last pixel read, results registered on exit
// COMMIT | done pulse, results visible, back to IDLE
module bbox_scan_engine #(
    parameter int IMG_W   = 100,
    parameter int IMG_H   = 100,
    parameter int PIX_W   = 8,
    parameter int COORD_W = 8
) (
    input logic               CLOCK_50,
    input logic               reset_n,
    bbox_scan_engine_if.slave bus
);
    localparam int N      = IMG_W * IMG_H;
    localparam int ADDR_W = $clog2(N);
    localparam int CNT_W  = $clog2(N + 1);

    localparam logic [ADDR_W:0]    N_EXT     = (ADDR_W + 1)'(N);
    localparam logic [ADDR_W-1:0]  LAST_ADDR = ADDR_W'(N - 1);
    localparam logic [COORD_W-1:0] X_LAST    = COORD_W'(IMG_W - 1);
    localparam logic [COORD_W-1:0] Y_LAST    = COORD_W'(IMG_H - 1);

    typedef enum logic [1:0] {IDLE, SCAN, DRAIN, COMMIT} state_t;

    state_t              state_q;
    logic [PIX_W-1:0]    mem [N];
    logic [PIX_W-1:0]    rd_data_q;
    logic [PIX_W-1:0]    thr_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [COORD_W-1:0]  x_q, y_q, xd_q, yd_q;
    logic                vld_q;
    logic [COORD_W-1:0]  wxmin_q, wxmax_q, wymin_q, wymax_q;
    logic [COORD_W-1:0]  wxmin_d, wxmax_d, wymin_d, wymax_d;
    logic [CNT_W-1:0]    wcnt_q, wcnt_d;
    logic                whit_q, whit_d;
    logic                busy_q, done_q, found_q;
    logic [COORD_W-1:0]  xmin_q, xmax_q, ymin_q, ymax_q;
    logic [CNT_W-1:0]    cnt_q;
    logic                wr_ok;
    logic                hit;

    assign wr_ok = bus.wr_en && (state_q == IDLE) && ({1'b0, bus.wr_addr} < N_EXT);

    // Frame store is deliberately outside the reset domain so a reset keeps the frame.
    always_ff @(posedge CLOCK_50) begin
        if (wr_ok) mem[bus.wr_addr] <= bus.wr_data;
        rd_data_q <= mem[addr_q];
    end

    assign hit = vld_q && (rd_data_q >= thr_q);

    always_comb begin
        wxmin_d = wxmin_q;
        wxmax_d = wxmax_q;
        wymin_d = wymin_q;
        wymax_d = wymax_q;
        wcnt_d  = wcnt_q;
        whit_d  = whit_q;
        if (hit) begin
            if (xd_q < wxmin_q) wxmin_d = xd_q;
            if (xd_q > wxmax_q) wxmax_d = xd_q;
            if (yd_q < wymin_q) wymin_d = yd_q;
            if (yd_q > wymax_q) wymax_d = yd_q;
            wcnt_d = wcnt_q + CNT_W'(1);
            whit_d = 1'b1;
        end
    end

    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            thr_q   <= '0;
            addr_q  <= '0;
            x_q     <= '0;
            y_q     <= '0;
            xd_q    <= '0;
            yd_q    <= '0;
            vld_q   <= 1'b0;
            wxmin_q <= '0;
            wxmax_q <= '0;
            wymin_q <= '0;
            wymax_q <= '0;
            wcnt_q  <= '0;
            whit_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            found_q <= 1'b0;
            xmin_q  <= '0;
            xmax_q  <= '0;
            ymin_q  <= '0;
            ymax_q  <= '0;
            cnt_q   <= '0;
        end else begin
            done_q  <= 1'b0;
            vld_q   <= (state_q == SCAN);
            xd_q    <= x_q;
            yd_q    <= y_q;
            wxmin_q <= wxmin_d;
            wxmax_q <= wxmax_d;
            wymin_q <= wymin_d;
            wymax_q <= wymax_d;
            wcnt_q  <= wcnt_d;
            whit_q  <= whit_d;
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        state_q <= SCAN;
                        busy_q  <= 1'b1;
                        thr_q   <= bus.threshold;
                        addr_q  <= '0;
                        x_q     <= '0;
                        y_q     <= '0;
                        wxmin_q <= X_LAST;
                        wymin_q <= Y_LAST;
                        wxmax_q <= '0;
                        wymax_q <= '0;
                        wcnt_q  <= '0;
                        whit_q  <= 1'b0;
                    end
                end
                SCAN: begin
                    if (addr_q == LAST_ADDR) begin
                        state_q <= DRAIN;
                    end else begin
                        addr_q <= addr_q + ADDR_W'(1);
                        if (x_q == X_LAST) begin
                            x_q <= '0;
                            y_q <= y_q + COORD_W'(1);
                        end else begin
                            x_q <= x_q + COORD_W'(1);
                        end
                    end
                end
                DRAIN: begin
                    // Results come from the _d terms so the last pixel is included.
                    state_q <= COMMIT;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                    found_q <= whit_d;
                    xmin_q  <= whit_d ? wxmin_d : '0;
                    xmax_q  <= whit_d ? wxmax_d : '0;
                    ymin_q  <= whit_d ? wymin_d : '0;
                    ymax_q  <= whit_d ? wymax_d : '0;
                    cnt_q   <= whit_d ? wcnt_d  : '0;
                end
                COMMIT: state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.found     = found_q;
    assign bus.xMin      = xmin_q;
    assign bus.xMax      = xmax_q;
    assign bus.yMin      = ymin_q;
    assign bus.yMax      = ymax_q;
    assign bus.pix_count = cnt_q;
endmodule
